// File: rtl/jpeg_zigzag_scan.sv
// jpeg_zigzag_scan: row-rate 8x8 block buffer (ping-pong) emitting coefficients in JPEG zig-zag order
module jpeg_zigzag_scan #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8*DATA_W-1:0] in_row,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_coef,
  output logic [5:0]          out_index,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready
);
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  typedef enum logic {IDLE, SCAN} state_t;
  state_t            state;
  logic [DATA_W-1:0] mem [2][64];
  logic [1:0]        full;
  logic              wr_ptr, rd_ptr, rd_oth, wr_fire;
  logic [2:0]        row_cnt;
  logic [5:0]        scan_cnt, scan_nxt;
  assign in_ready  = !full[wr_ptr];
  assign wr_fire   = in_valid && in_ready;
  assign rd_oth    = !rd_ptr;
  assign scan_nxt  = scan_cnt + 6'd1;
  assign out_index = scan_cnt;
  // Writes only ever target the non-full bank, so the bank being scanned is never disturbed.
  always_ff @(posedge clk)
    if (wr_fire)
      for (int c = 0; c < 8; c++) mem[wr_ptr][{row_cnt, 3'(c)}] <= in_row[(7 - c)*DATA_W +: DATA_W];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      full      <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      row_cnt   <= '0;
      scan_cnt  <= '0;
      out_coef  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (wr_fire) begin
        row_cnt <= row_cnt + 3'd1;
        if (row_cnt == 3'd7) begin
          full[wr_ptr] <= 1'b1;
          wr_ptr       <= !wr_ptr;
        end
      end
      if (state == IDLE) begin
        if (full[rd_ptr]) begin
          state     <= SCAN;
          scan_cnt  <= '0;
          out_coef  <= mem[rd_ptr][ZZ[0]];
          out_last  <= 1'b0;
          out_valid <= 1'b1;
        end
      end else if (out_ready) begin
        if (out_last) begin
          // Chain straight into the other bank when it is already full: no bubble.
          full[rd_ptr] <= 1'b0;
          rd_ptr       <= rd_oth;
          scan_cnt     <= '0;
          out_last     <= 1'b0;
          out_coef     <= mem[rd_oth][ZZ[0]];
          out_valid    <= full[rd_oth];
          state        <= full[rd_oth] ? SCAN : IDLE;
        end else begin
          scan_cnt <= scan_nxt;
          out_coef <= mem[rd_ptr][ZZ[scan_nxt]];
          out_last <= scan_nxt == 6'd63;
        end
      end
    end
endmodule

// File: tb/tb_jpeg_zigzag_scan.sv
// tb_jpeg_zigzag_scan: randomized scoreboard bench against a zig-zag reference model
module tb_jpeg_zigzag_scan;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_row = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_coef;
  logic [5:0]  out_index;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;

  jpeg_zigzag_scan #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .in_row(in_row), .in_valid(in_valid), .in_ready(in_ready),
    .out_coef(out_coef), .out_index(out_index), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int zz_r [64], zz_c [64];
  logic [7:0] blk [8][8];
  int wrow = 0, stored = 0, acc = 0, cyc = 0;
  logic [7:0] q_coef [$];
  int q_idx [$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_coef;
  logic [5:0] prev_idx;
  logic meas_lat = 1'b0;
  int t_row7 = -1;
  logic gap_on = 1'b0, gap_seen = 1'b0;
  int gaps = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Zig-zag order: walk anti-diagonals, alternating direction.
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0)
        for (int r = hi; r >= lo; r--) begin zz_r[k] = r; zz_c[k] = s - r; k++; end
      else
        for (int r = lo; r <= hi; r++) begin zz_r[k] = r; zz_c[k] = s - r; k++; end
    end
  endtask

  task automatic step(input logic v, input logic [63:0] row, input logic rdy);
    @(negedge clk);
    cyc++;
    check("in_ready", in_ready, stored < 2);
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_coef", out_coef, prev_coef);
      check("hold_index", out_index, prev_idx);
    end
    if (out_valid) begin
      if (q_coef.size() == 0) check("spurious_valid", out_valid, 0);
      else begin
        check("coef", out_coef, q_coef[0]);
        check("index", out_index, q_idx[0]);
        check("last", out_last, q_idx[0] == 63);
      end
      if (meas_lat && t_row7 >= 0) begin
        check("latency", cyc - t_row7, 2);
        meas_lat = 1'b0;
      end
    end
    if (gap_on) begin
      if (out_valid) gap_seen = 1'b1;
      else if (gap_seen && q_coef.size() > 0) gaps++;
    end
    in_valid = v; in_row = row; out_ready = rdy;
    if (v && in_ready) begin
      acc++;
      for (int c = 0; c < 8; c++) blk[wrow][c] = row[(7 - c)*8 +: 8];
      if (wrow == 7) begin
        for (int k = 0; k < 64; k++) begin q_coef.push_back(blk[zz_r[k]][zz_c[k]]); q_idx.push_back(k); end
        stored++;
        if (meas_lat) t_row7 = cyc;
      end
      wrow = (wrow + 1) % 8;
    end
    if (out_valid && rdy && q_coef.size() > 0) begin
      if (q_idx[0] == 63) stored--;
      void'(q_coef.pop_front());
      void'(q_idx.pop_front());
    end
    prev_stall = out_valid && !rdy;
    prev_coef = out_coef;
    prev_idx = out_index;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_coef", out_coef, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    q_coef.delete(); q_idx.delete();
    wrow = 0; stored = 0; prev_stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (q_coef.size() > 0 || out_valid); i++) step(1'b0, '0, 1'b1);
    check("drain", q_coef.size(), 0);
  endtask

  function automatic logic [63:0] rnd_row();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] ramp_row(input int r);
    logic [63:0] x;
    for (int c = 0; c < 8; c++) x[(7 - c)*8 +: 8] = 8'(8*r + c);
    return x;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic held;
    build_zz();
    do_reset();
    // Single ramp block with latency measurement
    meas_lat = 1'b1;
    for (int r = 0; r < 8; r++) step(1'b1, ramp_row(r), 1'b1);
    drain();
    check("latency_seen", meas_lat, 0);
    // Sparse block
    step(1'b1, {8'h42, 8'h01, 48'h0}, 1'b1);
    step(1'b1, 64'h0000_0000_0000_0C00, 1'b1);
    for (int r = 2; r < 8; r++) step(1'b1, '0, 1'b1);
    drain();
    // Three blocks back to back, no gaps expected
    acc = 0; gaps = 0; gap_seen = 1'b0; gap_on = 1'b1;
    for (int i = 0; i < 300 && acc < 24; i++) step(1'b1, rnd_row(), 1'b1);
    check("accepted_24", acc, 24);
    drain();
    gap_on = 1'b0;
    check("gaps", gaps, 0);
    // Backpressure: toggle out_ready, long stall at index 20
    held = 1'b0;
    for (int r = 0; r < 8; r++) step(1'b1, rnd_row(), 1'b0);
    for (int i = 0; i < 400 && q_coef.size() > 0; i++) begin
      if (!held && out_valid && out_index == 6'd20) begin
        for (int j = 0; j < 5; j++) step(1'b0, '0, 1'b0);
        held = 1'b1;
      end
      step(1'b0, '0, 1'(i % 2));
    end
    check("bp_held", held, 1);
    drain();
    // Reset after 5 rows, then a fresh block
    for (int r = 0; r < 5; r++) step(1'b1, rnd_row(), 1'b1);
    do_reset();
    for (int r = 0; r < 8; r++) step(1'b1, rnd_row(), 1'b1);
    drain();
    // Reset mid-scan at index 30, then a fresh block
    for (int r = 0; r < 8; r++) step(1'b1, rnd_row(), 1'b1);
    for (int i = 0; i < 100 && !(out_valid && out_index == 6'd30); i++) step(1'b0, '0, 1'b1);
    check("reached_30", out_index, 30);
    do_reset();
    for (int r = 0; r < 8; r++) step(1'b1, rnd_row(), 1'b1);
    drain();
    // Both banks full with output stalled: extra rows must be refused
    acc = 0;
    for (int i = 0; i < 30; i++) step(1'b1, rnd_row(), 1'b0);
    check("stall_accepted", acc, 16);
    check("stall_in_ready", in_ready, 0);
    drain();
    // Random soak
    for (int i = 0; i < 2000; i++) step(1'($urandom_range(0, 1)), rnd_row(), 1'($urandom_range(0, 3) != 0));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
